id_ex_reg: RTL

ID_EX_REG -- requirements
Module: id_ex_reg

---
 rtl/id_ex_reg_pkg.sv | 26 ++
 rtl/id_ex_reg_operand_bypass.sv | 22 ++
 rtl/id_ex_reg.sv | 120 ++++++++++++
 3 files changed

// File: rtl/id_ex_reg_pkg.sv
// Shared CPU pipeline definitions: datapath widths, control-bit positions, counter helpers.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package id_ex_reg_pkg;

  // Datapath widths shared by every pipeline register
  localparam int CPU_DATA_W = 16;
  localparam int CPU_REG_AW = 3;
  localparam int CTRL_W     = 8;
  localparam int BUBBLE_W   = 8;

  // Control-word bit positions: {alu_op[7:4], alu_src[3], mem_rd[2], mem_wr[1], reg_wr[0]}
  localparam int CTRL_MEM_RD = 2;
  localparam int CTRL_MEM_WR = 1;
  localparam int CTRL_REG_WR = 0;

  // Bits that cause architectural side effects; cleared when a slot carries no real instruction
  localparam logic [CTRL_W-1:0] CTRL_SIDE_EFFECT_MASK =
    (CTRL_W'(1) << CTRL_MEM_RD) | (CTRL_W'(1) << CTRL_MEM_WR) | (CTRL_W'(1) << CTRL_REG_WR);

  // Saturating increment: sticks at all-ones instead of wrapping
  function automatic logic [BUBBLE_W-1:0] sat_inc(input logic [BUBBLE_W-1:0] v);
    return (&v) ? v : v + BUBBLE_W'(1);
  endfunction

endpackage

// File: rtl/id_ex_reg_operand_bypass.sv
// Write-back bypass for one source operand: address compare plus 2:1 data select.
// Latency: combinational, 0 cycles.
// Backpressure: none; the enclosing register decides when the result is captured.
module operand_bypass #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3
) (
  input  logic [REG_AW-1:0] i_src_addr,
  input  logic [DATA_W-1:0] i_src_data,
  input  logic              i_wb_wr,
  input  logic [REG_AW-1:0] i_wb_addr,
  input  logic [DATA_W-1:0] i_wb_data,
  output logic [DATA_W-1:0] o_data
);

  logic w_hit;

  // No register is hardwired to zero, so R0 is bypassed like any other
  assign w_hit  = i_wb_wr && (i_wb_addr == i_src_addr);
  assign o_data = w_hit ? i_wb_data : i_src_data;

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with write-back bypass on rs/rt and a saturating bubble counter.
// Latency: 1 cycle from id_* to ex_*; reset clears all outputs asynchronously.
// Backpressure: stall holds every output; flush (wins over stall) inserts a bubble.
module id_ex_reg
  import id_ex_reg_pkg::*;
#(
  parameter int DATA_W = CPU_DATA_W,
  parameter int REG_AW = CPU_REG_AW
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                flush,
  input  logic                id_valid,
  input  logic [CTRL_W-1:0]   id_ctrl,
  input  logic [REG_AW-1:0]   id_rs_addr,
  input  logic [REG_AW-1:0]   id_rt_addr,
  input  logic [REG_AW-1:0]   id_rd_addr,
  input  logic [DATA_W-1:0]   id_rs_data,
  input  logic [DATA_W-1:0]   id_rt_data,
  input  logic [DATA_W-1:0]   id_imm,
  input  logic                wb_reg_wr,
  input  logic [REG_AW-1:0]   wb_rd_addr,
  input  logic [DATA_W-1:0]   wb_data,
  output logic                ex_valid,
  output logic [CTRL_W-1:0]   ex_ctrl,
  output logic [REG_AW-1:0]   ex_rs_addr,
  output logic [REG_AW-1:0]   ex_rt_addr,
  output logic [REG_AW-1:0]   ex_rd_addr,
  output logic [DATA_W-1:0]   ex_rs_data,
  output logic [DATA_W-1:0]   ex_rt_data,
  output logic [DATA_W-1:0]   ex_imm,
  output logic [BUBBLE_W-1:0] ex_bubble_cnt
);

  logic                r_valid;
  logic [CTRL_W-1:0]   r_ctrl;
  logic [REG_AW-1:0]   r_rs_addr;
  logic [REG_AW-1:0]   r_rt_addr;
  logic [REG_AW-1:0]   r_rd_addr;
  logic [DATA_W-1:0]   r_rs_data;
  logic [DATA_W-1:0]   r_rt_data;
  logic [DATA_W-1:0]   r_imm;
  logic [BUBBLE_W-1:0] r_bubble_cnt;

  logic [DATA_W-1:0]   w_rs_data;
  logic [DATA_W-1:0]   w_rt_data;
  logic [CTRL_W-1:0]   w_ctrl_in;
  logic                w_load;
  logic                w_bubble_evt;

  operand_bypass #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_rs_bypass (
    .i_src_addr (id_rs_addr),
    .i_src_data (id_rs_data),
    .i_wb_wr    (wb_reg_wr),
    .i_wb_addr  (wb_rd_addr),
    .i_wb_data  (wb_data),
    .o_data     (w_rs_data)
  );

  operand_bypass #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_rt_bypass (
    .i_src_addr (id_rt_addr),
    .i_src_data (id_rt_data),
    .i_wb_wr    (wb_reg_wr),
    .i_wb_addr  (wb_rd_addr),
    .i_wb_data  (wb_data),
    .o_data     (w_rt_data)
  );

  // A non-valid slot keeps its alu fields but must not touch memory or the register file
  assign w_ctrl_in    = id_valid ? id_ctrl : (id_ctrl & ~CTRL_SIDE_EFFECT_MASK);
  assign w_load       = !flush && !stall;
  assign w_bubble_evt = flush || (!stall && !id_valid);

  // Pipeline fields: flush clears only valid/ctrl, stall holds, otherwise load with bypassed operands
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid   <= 1'b0;
      r_ctrl    <= '0;
      r_rs_addr <= '0;
      r_rt_addr <= '0;
      r_rd_addr <= '0;
      r_rs_data <= '0;
      r_rt_data <= '0;
      r_imm     <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
    end else if (w_load) begin
      r_valid   <= id_valid;
      r_ctrl    <= w_ctrl_in;
      r_rs_addr <= id_rs_addr;
      r_rt_addr <= id_rt_addr;
      r_rd_addr <= id_rd_addr;
      r_rs_data <= w_rs_data;
      r_rt_data <= w_rt_data;
      r_imm     <= id_imm;
    end
  end

  // Bubble counter: counts flushes and non-valid loads, saturating rather than wrapping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bubble_cnt <= '0;
    end else if (w_bubble_evt) begin
      r_bubble_cnt <= sat_inc(r_bubble_cnt);
    end
  end

  assign ex_valid      = r_valid;
  assign ex_ctrl       = r_ctrl;
  assign ex_rs_addr    = r_rs_addr;
  assign ex_rt_addr    = r_rt_addr;
  assign ex_rd_addr    = r_rd_addr;
  assign ex_rs_data    = r_rs_data;
  assign ex_rt_data    = r_rt_data;
  assign ex_imm        = r_imm;
  assign ex_bubble_cnt = r_bubble_cnt;

endmodule
